lwe_inner_product_acc: RTL and testbench
========================================

Name: lwe_inner_product_acc

Overview:
Computes one LWE ciphertext body b = <a,s> + e + m*floor(q/2), wrapping at 2^N, before modular reduction. Accepts DIM coefficient pairs (a_i, s_i) over a valid/ready stream and multiplies each pair with a sequential shift-add multiplier. It then adds the error term and the message term, and presents the N-bit sum to the downstream modulus stage (as its dividend) over a valid/ready handshake.

Parameters:
N, 32, accumulator and output width (matches downstream modulus width)
IN_W, 16, width of each a_i / s_i coefficient; IN_W <= N
DIM, 8, number of coefficient pairs per operation; DIM >= 1

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin operation; sampled only in IDLE
err_in  input  N  error term e; latched when start is accepted
msg_in  input  1  message bit m; latched when start is accepted
q_half  input  N  floor(q/2); latched when start is accepted
a_in  input  IN_W  coefficient a_i
s_in  input  IN_W  secret coefficient s_i
in_valid  input  1  a_in/s_in valid
in_ready  output  1  block accepts a pair this cycle
sum_out  output  N  result, wrapped mod 2^N
out_valid  output  1  sum_out valid
out_ready  input  1  downstream accepts sum_out
overflow  output  1  sticky: some addition in this operation carried out of N bits
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: asynchronous, active-high. State goes to IDLE. All outputs are 0: in_ready, out_valid, sum_out, overflow, busy. Internal accumulator, pair counter and bit counter are cleared. Asserting rst mid-operation aborts the operation; no partial result is ever presented.
- All outputs are registered or decoded from the registered state. in_ready = (state==ACCEPT). out_valid = (state==OUTPUT).
- IDLE: start=1 at an edge latches err_in, msg_in and q_half, clears acc, pair_cnt and overflow, and moves to ACCEPT. start is ignored in every other state.
- ACCEPT: in_ready=1. in_valid&in_ready at an edge latches mcand = zero-extend(a_in) to N bits and mplier = s_in, sets bit_cnt=0, and moves to MULT. in_valid low means the block stalls here indefinitely.
- MULT: takes exactly IN_W cycles, with no early termination. Each cycle:
  - if mplier[0]=1, acc <= acc + mcand (N+1-bit add); carry-out sets overflow.
  - mcand <= mcand << 1, truncated to N bits (upper bits dropped for IN_W=N/2 is impossible: 2*IN_W <= N by default).
  - mplier >>= 1; bit_cnt += 1.
  - When bit_cnt==IN_W-1: if pair_cnt==DIM-1, go to ADD_NOISE; else pair_cnt += 1 and go to ACCEPT.
- ADD_NOISE (1 cycle): acc <= acc + err + (msg ? q_half : 0), computed in N+2 bits and truncated to N. Any nonzero bit above N-1 sets overflow. Then go to OUTPUT.
- OUTPUT: out_valid=1 and sum_out=acc. Both hold stable until out_valid&out_ready at an edge; then go to IDLE, and out_valid is low the next cycle. sum_out keeps its last value in IDLE. overflow holds until the next accepted start.
- Latency with in_valid held high and out_ready high: out_valid first rises 2 + DIM*(1+IN_W) edges after the start edge. With defaults this is 138.
- Throughput: one result per operation. A new start is accepted in the cycle after the output handshake at the earliest.
- Arithmetic: unsigned. The result is exact mod 2^N. overflow reports loss of the true sum; the downstream modulus stage does not see it.

Test Plan:
- a_i=i+1, s_i=2 (i=0..7), err=5, msg=0 -> sum_out=77, overflow=0, out_valid at edge 138 after start.
- All a_i=s_i=0, err=3, msg=1, q_half=0x4000_0000 -> sum_out=0x4000_0003, overflow=0.
- All a_i=s_i=0xFFFF, err=0, msg=0 -> sum_out=0xFFF0_0008, overflow=1. A following start with zero inputs -> overflow cleared, sum_out=0.
- in_valid toggled 1-0-1 with random gaps and out_ready held low 10 cycles, using the stimulus of test 1 -> sum_out=77. in_ready is high only in ACCEPT. out_valid and sum_out are stable through the stall.
- start pulsed during MULT and during OUTPUT -> ignored, result unchanged, busy stays 1 until the output handshake.
- rst asserted mid-MULT on the 4th pair -> all outputs 0 immediately with no clock edge needed. A fresh start with the test 1 stimulus -> 77.

Source files
------------

// File: rtl/lwe_inner_product_acc.sv
// lwe_inner_product_acc
//   Computes one LWE ciphertext body b = <a,s> + e + m*floor(q/2), wrapping
//   at 2^N. DIM coefficient pairs arrive over a valid/ready stream. Each pair
//   is multiplied with a sequential shift-add multiplier (IN_W cycles) and
//   accumulated. The error and message terms are added in one final cycle.
//
// Handshakes: a transfer happens at a rising clk edge where valid && ready.
//   Ready never depends combinationally on valid. The producer holds its
//   payload stable while valid is high and ready is low.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             begin an operation (only looked at in IDLE)
//   err_in/msg_in/q_half  e, m and floor(q/2), latched with start
//   a_in/s_in         coefficient pair, qualified by in_valid / in_ready
//   sum_out           N-bit wrapped result, qualified by out_valid / out_ready
//   overflow          sticky: some addition carried out of N bits
//   busy              high whenever the block is not IDLE
module lwe_inner_product_acc #(
  parameter int N    = 32,
  parameter int IN_W = 16,
  parameter int DIM  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N-1:0]    err_in,
  input  logic            msg_in,
  input  logic [N-1:0]    q_half,
  input  logic [IN_W-1:0] a_in,
  input  logic [IN_W-1:0] s_in,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N-1:0]    sum_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            overflow,
  output logic            busy
);

  localparam int PW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int BW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [PW-1:0] PAIR_LAST = PW'(DIM - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(IN_W - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ACCEPT    = 3'd1,
    S_MULT      = 3'd2,
    S_ADD_NOISE = 3'd3,
    S_OUTPUT    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [N-1:0]    mcand_q, mcand_d;
  logic [IN_W-1:0] mplier_q, mplier_d;
  logic [N-1:0]    err_q, err_d;
  logic [N-1:0]    qh_q, qh_d;
  logic            msg_q, msg_d;
  logic            ovf_q, ovf_d;
  logic [PW-1:0]   pair_q, pair_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [N-1:0]    sum_q, sum_d;

  // One partial-product add per MULT cycle; bit N is the carry-out.
  logic [N:0]   mult_sum;
  // Three-operand add for the noise step; two guard bits catch any carry.
  logic [N+1:0] noise_sum;

  assign mult_sum  = {1'b0, acc_q} + {1'b0, mcand_q};
  assign noise_sum = {2'b00, acc_q} + {2'b00, err_q} + (msg_q ? {2'b00, qh_q} : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      err_q    <= '0;
      qh_q     <= '0;
      msg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      pair_q   <= '0;
      bit_q    <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      err_q    <= err_d;
      qh_q     <= qh_d;
      msg_q    <= msg_d;
      ovf_q    <= ovf_d;
      pair_q   <= pair_d;
      bit_q    <= bit_d;
      sum_q    <= sum_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    err_d    = err_q;
    qh_d     = qh_q;
    msg_d    = msg_q;
    ovf_d    = ovf_q;
    pair_d   = pair_q;
    bit_d    = bit_q;
    sum_d    = sum_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d   = err_in;
          msg_d   = msg_in;
          qh_d    = q_half;
          acc_d   = '0;
          pair_d  = '0;
          ovf_d   = 1'b0;
          state_d = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (in_valid) begin
          mcand_d  = N'(a_in);
          mplier_d = s_in;
          bit_d    = '0;
          state_d  = S_MULT;
        end
      end
      S_MULT: begin
        if (mplier_q[0]) begin
          acc_d = mult_sum[N-1:0];
          if (mult_sum[N]) ovf_d = 1'b1;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        bit_d    = bit_q + 1'b1;
        // Always IN_W cycles, even when the remaining multiplier bits are zero.
        if (bit_q == BIT_LAST) begin
          if (pair_q == PAIR_LAST) begin
            state_d = S_ADD_NOISE;
          end else begin
            pair_d  = pair_q + 1'b1;
            state_d = S_ACCEPT;
          end
        end
      end
      S_ADD_NOISE: begin
        acc_d   = noise_sum[N-1:0];
        // sum_out is a separate register so it keeps the last result through
        // IDLE and the next operation, while acc is cleared on start.
        sum_d   = noise_sum[N-1:0];
        if (|noise_sum[N+1:N]) ovf_d = 1'b1;
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_ACCEPT);
  assign out_valid = (state_q == S_OUTPUT);
  assign busy      = (state_q != S_IDLE);
  assign sum_out   = sum_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_lwe_inner_product_acc.sv
// Testbench for lwe_inner_product_acc. The reference model sums the products
// with 64-bit integer arithmetic and derives the wrapped sum and overflow
// from the true total.
module tb_lwe_inner_product_acc;
  localparam int N    = 32;
  localparam int IN_W = 16;
  localparam int DIM  = 8;
  localparam int LAT  = 2 + DIM * (1 + IN_W);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic            start = 1'b0;
  logic [N-1:0]    err_in = '0;
  logic            msg_in = 1'b0;
  logic [N-1:0]    q_half = '0;
  logic [IN_W-1:0] a_in = '0;
  logic [IN_W-1:0] s_in = '0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic            in_ready;
  logic [N-1:0]    sum_out;
  logic            out_valid;
  logic            overflow;
  logic            busy;

  lwe_inner_product_acc #(.N(N), .IN_W(IN_W), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .start(start), .err_in(err_in), .msg_in(msg_in),
    .q_half(q_half), .a_in(a_in), .s_in(s_in), .in_valid(in_valid),
    .in_ready(in_ready), .sum_out(sum_out), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // operation stimulus
  logic [IN_W-1:0] a_arr[DIM];
  logic [IN_W-1:0] s_arr[DIM];
  logic [N-1:0]    op_err, op_qh;
  logic            op_msg;

  // observations from the last operation
  logic [N-1:0] got_sum;
  logic         got_ovf;
  int           got_lat;
  bit           got_to;
  int           rdy_bad;
  int           stall_bad;
  logic         post_valid, post_busy, post_ovf;

  // reference model
  function automatic void ref_model(output logic [N-1:0] sum, output logic ovf);
    longint unsigned t;
    t = 0;
    for (int i = 0; i < DIM; i++) t += 64'(a_arr[i]) * 64'(s_arr[i]);
    t += 64'(op_err);
    if (op_msg) t += 64'(op_qh);
    sum = t[N-1:0];
    ovf = (t >> N) != 0;
  endfunction

  // driver tasks
  task automatic drive_pair(input logic [IN_W-1:0] a, input logic [IN_W-1:0] s, output bit to);
    int guard;
    guard = 0;
    @(negedge clk);
    a_in = a; s_in = s; in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    to = !in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in = IN_W'($urandom);
    s_in = IN_W'($urandom);
    if (in_ready) rdy_bad++;   // must have left ACCEPT for MULT
  endtask

  task automatic do_op(input int max_gap, input int stall, input bit poke,
                       input int abort_pair, output bit aborted);
    int start_cyc, g;
    bit to;
    aborted = 0; got_to = 0; rdy_bad = 0; stall_bad = 0;
    @(negedge clk);
    start = 1'b1; err_in = op_err; msg_in = op_msg; q_half = op_qh;
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    start = 1'b0; start_cyc = cyc;
    // change the latched operands so that a missing latch shows up
    err_in = $urandom; q_half = $urandom; msg_in = ~op_msg;
    for (int i = 0; i < DIM; i++) begin
      g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      repeat (g) @(negedge clk);
      drive_pair(a_arr[i], s_arr[i], to);
      got_to |= to;
      if (i == abort_pair) begin
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        aborted = 1;
        return;
      end
      if (poke && i == 3) begin
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (!busy || in_ready) stall_bad++;
      end
    end
    g = 0;
    while (!out_valid && g < 1000) begin
      @(negedge clk);
      g++;
    end
    got_to |= !out_valid;
    got_lat = cyc - start_cyc + 1;   // the start edge itself is edge 1
    got_sum = sum_out;
    got_ovf = overflow;
    for (int k = 0; k < stall; k++) begin
      if (poke && k == 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (!out_valid || sum_out !== got_sum || !busy) stall_bad++;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    post_valid = out_valid;
    post_busy  = busy;
    post_ovf   = overflow;
  endtask

  task automatic load_test1();
    for (int i = 0; i < DIM; i++) begin
      a_arr[i] = IN_W'(i + 1);
      s_arr[i] = IN_W'(2);
    end
    op_err = 32'd5; op_msg = 1'b0; op_qh = $urandom;
  endtask

  task automatic load_random();
    for (int i = 0; i < DIM; i++) begin
      a_arr[i] = IN_W'($urandom);
      s_arr[i] = IN_W'($urandom);
    end
    op_err = $urandom; op_msg = 1'($urandom_range(0, 1)); op_qh = $urandom;
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (sum_out !== '0) begin n_bad++; $display("FAIL reset_sum_out got=%h exp=0", sum_out); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [N-1:0] e_sum; logic e_ovf; bit ab;
    load_test1();
    ref_model(e_sum, e_ovf);
    do_op(0, 0, 0, -1, ab);
    n_cmp++; if (got_to) begin n_bad++; $display("FAIL basic_timeout got=1 exp=0"); end
    n_cmp++; if (got_sum !== e_sum) begin n_bad++; $display("FAIL basic_sum got=%0d exp=%0d", got_sum, e_sum); end
    n_cmp++; if (got_ovf !== e_ovf) begin n_bad++; $display("FAIL basic_ovf got=%b exp=%b", got_ovf, e_ovf); end
    n_cmp++; if (got_lat != LAT) begin n_bad++; $display("FAIL basic_latency got=%0d exp=%0d", got_lat, LAT); end
    n_cmp++; if (rdy_bad != 0) begin n_bad++; $display("FAIL basic_in_ready_in_mult got=%0d exp=0", rdy_bad); end
    n_cmp++; if (post_valid !== 1'b0 || post_busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_after_handshake valid=%b busy=%b exp=0/0", post_valid, post_busy); end
    n_cmp++; if (sum_out !== e_sum) begin n_bad++; $display("FAIL basic_sum_held_idle got=%h exp=%h", sum_out, e_sum); end
  endtask

  task automatic test_message();
    logic [N-1:0] e_sum; logic e_ovf; bit ab;
    for (int i = 0; i < DIM; i++) begin a_arr[i] = '0; s_arr[i] = '0; end
    op_err = 32'd3; op_msg = 1'b1; op_qh = 32'h4000_0000;
    ref_model(e_sum, e_ovf);
    do_op(0, 0, 0, -1, ab);
    n_cmp++; if (got_sum !== e_sum) begin n_bad++; $display("FAIL msg_sum got=%h exp=%h", got_sum, e_sum); end
    n_cmp++; if (got_ovf !== e_ovf) begin n_bad++; $display("FAIL msg_ovf got=%b exp=%b", got_ovf, e_ovf); end
  endtask

  task automatic test_overflow();
    logic [N-1:0] e_sum; logic e_ovf; bit ab;
    for (int i = 0; i < DIM; i++) begin a_arr[i] = '1; s_arr[i] = '1; end
    op_err = '0; op_msg = 1'b0; op_qh = $urandom;
    ref_model(e_sum, e_ovf);
    do_op(0, 0, 0, -1, ab);
    n_cmp++; if (got_sum !== e_sum) begin n_bad++; $display("FAIL ovf_sum got=%h exp=%h", got_sum, e_sum); end
    n_cmp++; if (got_ovf !== e_ovf) begin n_bad++; $display("FAIL ovf_flag got=%b exp=%b", got_ovf, e_ovf); end
    n_cmp++; if (post_ovf !== e_ovf) begin n_bad++; $display("FAIL ovf_held_idle got=%b exp=%b", post_ovf, e_ovf); end
    for (int i = 0; i < DIM; i++) begin a_arr[i] = '0; s_arr[i] = '0; end
    op_err = '0; op_msg = 1'b0;
    ref_model(e_sum, e_ovf);
    do_op(0, 0, 0, -1, ab);
    n_cmp++; if (got_sum !== e_sum) begin n_bad++; $display("FAIL ovf_clear_sum got=%h exp=%h", got_sum, e_sum); end
    n_cmp++; if (got_ovf !== e_ovf) begin n_bad++; $display("FAIL ovf_clear_flag got=%b exp=%b", got_ovf, e_ovf); end
  endtask

  task automatic test_random();
    logic [N-1:0] e_sum; logic e_ovf; bit ab;
    for (int r = 0; r < 6; r++) begin
      load_random();
      ref_model(e_sum, e_ovf);
      do_op(3, 0, 0, -1, ab);
      n_cmp++; if (got_to || got_sum !== e_sum) begin
        n_bad++; $display("FAIL random%0d_sum got=%h exp=%h timeout=%0b", r, got_sum, e_sum, got_to); end
      n_cmp++; if (got_ovf !== e_ovf) begin n_bad++; $display("FAIL random%0d_ovf got=%b exp=%b", r, got_ovf, e_ovf); end
    end
  endtask

  task automatic test_stall();
    logic [N-1:0] e_sum; logic e_ovf; bit ab;
    load_test1();
    ref_model(e_sum, e_ovf);
    do_op(4, 10, 0, -1, ab);
    n_cmp++; if (got_sum !== e_sum) begin n_bad++; $display("FAIL stall_sum got=%0d exp=%0d", got_sum, e_sum); end
    n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL stall_output_unstable got=%0d exp=0", stall_bad); end
    n_cmp++; if (rdy_bad != 0) begin n_bad++; $display("FAIL stall_in_ready got=%0d exp=0", rdy_bad); end
  endtask

  task automatic test_start_ignored();
    logic [N-1:0] e_sum; logic e_ovf; bit ab;
    load_random();
    ref_model(e_sum, e_ovf);
    do_op(1, 3, 1, -1, ab);
    n_cmp++; if (got_sum !== e_sum) begin n_bad++; $display("FAIL poke_sum got=%h exp=%h", got_sum, e_sum); end
    n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL poke_busy_or_output got=%0d exp=0", stall_bad); end
    n_cmp++; if (post_busy !== 1'b0 || post_valid !== 1'b0) begin
      n_bad++; $display("FAIL poke_after_handshake busy=%b valid=%b exp=0/0", post_busy, post_valid); end
  endtask

  task automatic test_reset_abort();
    logic [N-1:0] e_sum; logic e_ovf; bit ab;
    load_random();
    do_op(0, 0, 0, 3, ab);
    #1;   // still between clock edges
    n_cmp++; if (!ab || {in_ready, out_valid, overflow, busy} !== 4'b0 || sum_out !== '0) begin
      n_bad++;
      $display("FAIL abort_outputs rdy=%b vld=%b ovf=%b busy=%b sum=%h exp=all 0",
               in_ready, out_valid, overflow, busy, sum_out);
    end
    @(negedge clk);
    rst = 1'b0;
    load_test1();
    ref_model(e_sum, e_ovf);
    do_op(0, 0, 0, -1, ab);
    n_cmp++; if (got_sum !== e_sum) begin n_bad++; $display("FAIL abort_fresh_sum got=%0d exp=%0d", got_sum, e_sum); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] e_sum; logic e_ovf; bit ab;
    for (int r = 0; r < 3; r++) begin
      load_random();
      ref_model(e_sum, e_ovf);
      do_op(0, 0, 0, -1, ab);
      n_cmp++; if (got_sum !== e_sum || got_ovf !== e_ovf) begin
        n_bad++; $display("FAIL b2b%0d sum=%h ovf=%b exp sum=%h ovf=%b", r, got_sum, got_ovf, e_sum, e_ovf); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_message();
    test_overflow();
    test_random();
    test_stall();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
